button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_channel.sv | 123 ++++++++++++
 rtl/button_conditioner.sv | 55 +++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Channel FSM states, counter widths and channel indices.
package btn_pkg;

  localparam int DB_W   = 4;
  localparam int HOLD_W = 11;

  localparam int CH_FLIP = 0;
  localparam int CH_RST  = 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    HELD        = 3'd3,
    DEB_RELEASE = 3'd4
  } btn_st_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce/long-press FSM,
// registered press/long pulses and debounced level.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DB_CNT   = 4,
  parameter int LONG_CNT = 1024
) (
  input  logic clk_216,
  input  logic rst_n,
  input  logic raw,
  output logic press_p,
  output logic long_p,
  output logic level
);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DB_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(LONG_CNT - 1);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic s1, sync;
  btn_st_e state, state_n;
  logic [DB_W-1:0] db_cnt, db_cnt_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic held, held_n;
  logic press_n, long_n, level_n;

  always_ff @(posedge clk_216) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      sync     <= 1'b0;
      state    <= IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
      held     <= 1'b0;
      press_p  <= 1'b0;
      long_p   <= 1'b0;
      level    <= 1'b0;
    end else begin
      s1       <= raw;
      sync     <= s1;
      state    <= state_n;
      db_cnt   <= db_cnt_n;
      hold_cnt <= hold_cnt_n;
      held     <= held_n;
      press_p  <= press_n;
      long_p   <= long_n;
      level    <= level_n;
    end
  end

  always_comb begin
    state_n    = state;
    db_cnt_n   = db_cnt;
    hold_cnt_n = hold_cnt;
    held_n     = held;
    press_n    = 1'b0;
    long_n     = 1'b0;
    level_n    = level;
    unique case (state)
      IDLE: begin
        if (sync) begin
          state_n  = DEB_PRESS;
          db_cnt_n = DB_ONE;
        end
      end
      DEB_PRESS: begin
        if (!sync) begin
          state_n  = IDLE;
          db_cnt_n = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n    = PRESSED;
          db_cnt_n   = '0;
          hold_cnt_n = '0;
          press_n    = 1'b1;
          level_n    = 1'b1;
        end else begin
          db_cnt_n = db_cnt + DB_ONE;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_n  = DEB_RELEASE;
          held_n   = 1'b0;
          db_cnt_n = DB_ONE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n    = HELD;
          hold_cnt_n = hold_cnt + HOLD_ONE;
          long_n     = 1'b1;
        end else if (hold_cnt != '1) begin
          hold_cnt_n = hold_cnt + HOLD_ONE;
        end
      end
      HELD: begin
        if (!sync) begin
          state_n  = DEB_RELEASE;
          held_n   = 1'b1;
          db_cnt_n = DB_ONE;
        end
      end
      DEB_RELEASE: begin
        // A bounce back high resumes the press without re-announcing it
        if (sync) begin
          state_n  = held ? HELD : PRESSED;
          db_cnt_n = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n  = IDLE;
          db_cnt_n = '0;
          level_n  = 1'b0;
        end else begin
          db_cnt_n = db_cnt + DB_ONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner plus synchronized enable switch.
// Channel 0 is the flip button, channel 1 the counter reset request.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DB_CNT   = 4,
  parameter int LONG_CNT = 1024
) (
  input  logic       clk_216,
  input  logic       rst_n,
  input  logic [1:0] btn_in,
  input  logic       sw_en,
  output logic [1:0] press_p,
  output logic [1:0] long_p,
  output logic [1:0] level,
  output logic       en_sync
);

  logic en_s1;

  always_ff @(posedge clk_216) begin
    if (!rst_n) begin
      en_s1   <= 1'b0;
      en_sync <= 1'b0;
    end else begin
      en_s1   <= sw_en;
      en_sync <= en_s1;
    end
  end

  btn_channel #(
    .DB_CNT  (DB_CNT),
    .LONG_CNT(LONG_CNT)
  ) u_flip (
    .clk_216(clk_216),
    .rst_n  (rst_n),
    .raw    (btn_in[CH_FLIP]),
    .press_p(press_p[CH_FLIP]),
    .long_p (long_p[CH_FLIP]),
    .level  (level[CH_FLIP])
  );

  btn_channel #(
    .DB_CNT  (DB_CNT),
    .LONG_CNT(LONG_CNT)
  ) u_rst (
    .clk_216(clk_216),
    .rst_n  (rst_n),
    .raw    (btn_in[CH_RST]),
    .press_p(press_p[CH_RST]),
    .long_p (long_p[CH_RST]),
    .level  (level[CH_RST])
  );

endmodule
